button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions the raw active-low push-button of the Fibonacci board before it reaches the falling-edge detector that launches a computation. It synchronises the asynchronous pad signal, rejects contact bounce with a stability counter and FSM, and provides:
- a clean debounced level;
- one-cycle press and release ticks;
- an optional auto-repeat tick, so a held button can step `in_bin`-style counters.

## Interface
Parameters:
- `DB_CYCLES`, 1_000_000, consecutive synchronised cycles the input must hold a new value before it is accepted; legal range ≥ 2.
- `REPEAT_CYCLES`, 0, period of `repeat_tick` while held; 0 disables auto-repeat.
- `ACTIVE_LOW`, 1, 1 means the pad reads 0 when pressed.

Ports:
- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  1  raw button pad, asynchronous to `clk`.
- `db_level`  output  1  debounced state: 1 means pressed, regardless of `ACTIVE_LOW`.
- `press_tick`  output  1  one-cycle pulse on an accepted press.
- `release_tick`  output  1  one-cycle pulse on an accepted release.
- `repeat_tick`  output  1  one-cycle pulse every `REPEAT_CYCLES` while held.

## Operation
- **Synchroniser:** a 2-flop chain samples `in`. Its output is normalised to `p` (1 = pressed) using `ACTIVE_LOW`.
- **FSM states:** `RELEASED`, `WAIT_PRESS`, `PRESSED`, `WAIT_RELEASE`.
  - `RELEASED`: `p=1` → `WAIT_PRESS`, counter cleared.
  - `WAIT_PRESS`:
    - `p=0` → `RELEASED` (bounce rejected, no tick).
    - else if counter == `DB_CYCLES-1` → `PRESSED`, assert `press_tick`.
    - else counter increments.
  - `PRESSED`: `p=0` → `WAIT_RELEASE`, counter cleared.
  - `WAIT_RELEASE`:
    - `p=1` → `PRESSED` (no tick).
    - else if counter == `DB_CYCLES-1` → `RELEASED`, assert `release_tick`.
    - else counter increments.
- **Counters:**
  - The debounce counter is `$clog2(DB_CYCLES)` bits wide. It is never compared outside `WAIT_*`, so wrap-around is impossible.
  - The repeat counter is `$clog2(REPEAT_CYCLES+1)` bits wide. It is cleared on entry to `PRESSED`, counts only in `PRESSED`, and emits `repeat_tick` when it reaches `REPEAT_CYCLES-1`, then reloads 0.
  - The repeat counter holds its value in `WAIT_RELEASE`. It resumes if the FSM returns to `PRESSED` via a bounce.
  - With `REPEAT_CYCLES=0`, `repeat_tick` is tied low and the counter is removed.
- **Level output:** `db_level` = 1 in `PRESSED` and `WAIT_RELEASE`, 0 otherwise.
- **Mutual exclusion:** at most one of `press_tick`, `release_tick`, `repeat_tick` is high in any cycle.

## Timing
- **Reset values:**
  - Outputs: `db_level`=0, all ticks 0.
  - State `RELEASED`, both counters 0.
  - Synchroniser flops preset to the released pad level (1 when `ACTIVE_LOW`), so no spurious press follows reset.
- **Reset mid-operation:** reset in any state returns to `RELEASED` on the next edge and drops an in-flight tick. A button still held afterward is re-qualified: a full `DB_CYCLES` is required and a fresh `press_tick` is produced.
- **Press latency:** raw input first sampled pressed at edge 1 and held → `p` visible after edge 2 → `WAIT_PRESS` after edge 3 → `press_tick` high after edge `DB_CYCLES+3`, for exactly one cycle. Release latency is symmetric.
- **Registered outputs:** all outputs are registered with no combinational path from `in`.
- **First repeat:** the first `repeat_tick` comes `REPEAT_CYCLES` cycles after `press_tick`, then every `REPEAT_CYCLES` cycles.
- **Bounce filtering:** any `p` glitch shorter than `DB_CYCLES` cycles, in either direction, produces no tick and no `db_level` change.

## Structure
- Shared header `debouncer_defs.vh` holds:
  - the 2-bit state encodings `RELEASED`=0, `WAIT_PRESS`=1, `PRESSED`=2, `WAIT_RELEASE`=3;
  - the 50 MHz / 20 ms default for `DB_CYCLES`.
- One sub-module, `sync_2ff`:
  - parameter `INIT` for the reset value;
  - ports `clk`, `reset`, `d`, `q`.
- The top of the design feeds `db_level`, inverted back to active-low, or `press_tick` directly into the start path.

## Test plan
Bench parameters: `DB_CYCLES=4`, `REPEAT_CYCLES=8`, `ACTIVE_LOW=1`.

- **Clean press:** reset, then `in` 1→0 held → `press_tick` high only in cycle 7 after the drop, `db_level` 1 from the same cycle.
- **Bounce rejection:** `in` pulses 0 for 3 cycles, 1 for 2 cycles, repeated 5 times, then held 1 → `press_tick` never asserts, `db_level` stays 0.
- **Bounced press:** 0/1 chatter for 10 cycles, then held 0 → exactly one `press_tick`, 7 cycles after the last 1→0 edge.
- **Auto-repeat:** press held 40 cycles after `press_tick` → `repeat_tick` at +8, +16, +24, +32, +40. Release → `release_tick` 7 cycles after `in` returns to 1, and no further repeats.
- **Reset while held:** reset asserted in `PRESSED` for 1 cycle with `in`=0 held → outputs 0 next cycle, then a new `press_tick` 7 cycles after reset deasserts.
- **Power-up:** reset with `in`=1 → no tick in the first 20 cycles.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - state encoding and default timing for the button debouncer
package button_debouncer_pkg;

  // Debounce FSM states; the encodings are shared with anything decoding the state
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } db_state_e;

  // Default qualification window: 20 ms of stable input at a 50 MHz system clock
  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned DB_MS             = 20;
  localparam int unsigned DB_CYCLES_DEFAULT = CLK_HZ / 1000 * DB_MS;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// rtl/button_debouncer_sync_2ff.sv - two-flop synchroniser with a configurable reset level
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // The pad sample simply shifts down the two-stage chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages reset to the idle pad level so leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= INIT;
      sync_q <= INIT;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button debouncer with press/release/auto-repeat ticks
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DB_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_CYCLES = 0,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic db_level,
  output logic press_tick,
  output logic release_tick,
  output logic repeat_tick
);

  localparam int unsigned      CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic pad_sync;
  logic p;

  sync_2ff #(
    .INIT (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (pad_sync)
  );

  // p is 1 while the synchronised pad reads pressed, whatever the pad polarity
  assign p = ACTIVE_LOW ? ~pad_sync : pad_sync;

  db_state_e        state_q;
  db_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_level_q;
  logic             db_level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Next-state logic: a new level must survive the whole counter window to be accepted
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (p) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!p) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (p) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    db_level_d = (state_d == PRESSED) || (state_d == WAIT_RELEASE);
  end

  // FSM state, counter and registered outputs; reset drops any tick in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RELEASED;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      press_q    <= press_d;
      release_q  <= release_d;
    end
  end

  assign db_level     = db_level_q;
  assign press_tick   = press_q;
  assign release_tick = release_q;

  generate
    if (REPEAT_CYCLES > 0) begin : g_repeat
      localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES + 1);
      localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

      logic [REP_W-1:0] rep_cnt_q;
      logic [REP_W-1:0] rep_cnt_d;
      logic             repeat_q;
      logic             repeat_d;

      // Restart the period on a fresh press; hold (not clear) while a release is being qualified
      always_comb begin
        rep_cnt_d = rep_cnt_q;
        repeat_d  = 1'b0;
        if (press_d) begin
          rep_cnt_d = '0;
        end else if (state_q == PRESSED) begin
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
      end

      // Repeat counter and its registered tick
      always_ff @(posedge clk) begin
        if (reset) begin
          rep_cnt_q <= '0;
          repeat_q  <= 1'b0;
        end else begin
          rep_cnt_q <= rep_cnt_d;
          repeat_q  <= repeat_d;
        end
      end

      assign repeat_tick = repeat_q;
    end else begin : g_no_repeat
      assign repeat_tick = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_pad;
  logic       db_level;
  logic       press_tick;
  logic       release_tick;
  logic       repeat_tick;
  logic [3:0] obs;
  int         checks = 0;
  int         errors = 0;

  button_debouncer #(
    .DB_CYCLES     (4),
    .REPEAT_CYCLES (8),
    .ACTIVE_LOW    (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in_pad),
    .db_level     (db_level),
    .press_tick   (press_tick),
    .release_tick (release_tick),
    .repeat_tick  (repeat_tick)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // observed vector packing: {db_level, press_tick, release_tick, repeat_tick}
  assign obs = {db_level, press_tick, release_tick, repeat_tick};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    in_pad = 1'b1;
    step();
    step();
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got %b expected %b", obs, 4'b0000);
    end
    reset = 1'b0;
  endtask

  task automatic test_power_up();
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL power_up k=%0d got %b expected %b", k, obs, 4'b0000);
      end
    end
  endtask

  task automatic test_release(input string name, input int n);
    logic [3:0] exp_v;
    in_pad = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step();
      exp_v = {k < 7, 1'b0, k == 7, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s k=%0d got %b expected %b", name, k, obs, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_v;
    in_pad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_v = {k >= 7, k == 7, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL clean_press k=%0d got %b expected %b", k, obs, exp_v);
      end
    end
    test_release("clean_release", 10);
  endtask

  task automatic test_bounce_reject();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 5; k++) begin
        in_pad = (k >= 3);
        step();
        checks++;
        if (obs !== 4'b0000) begin
          errors++;
          $display("FAIL bounce_reject r=%0d k=%0d got %b expected %b", r, k, obs, 4'b0000);
        end
      end
    end
    // a pulse exactly DB_CYCLES long is still one sample short of acceptance
    for (int k = 1; k <= 16; k++) begin
      in_pad = (k > 4 && k <= 12) ? 1'b1 : (k <= 4 ? 1'b0 : 1'b1);
      if (k > 4) in_pad = 1'b1;
      step();
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_db_pulse k=%0d got %b expected %b", k, obs, 4'b0000);
      end
    end
  endtask

  task automatic test_min_press();
    logic [3:0] exp_v;
    in_pad = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_v = {k >= 7 && k < 12, k == 7, k == 12, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL min_press k=%0d got %b expected %b", k, obs, exp_v);
      end
      if (k == 5) in_pad = 1'b1;
    end
  endtask

  task automatic test_bounced_press();
    logic [3:0] exp_v;
    for (int j = 0; j < 10; j++) begin
      in_pad = (j % 2 == 1);
      step();
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL bounced_chatter j=%0d got %b expected %b", j, obs, 4'b0000);
      end
    end
    in_pad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_v = {k >= 7, k == 7, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL bounced_press k=%0d got %b expected %b", k, obs, exp_v);
      end
    end
    test_release("bounced_release", 10);
  endtask

  task automatic test_auto_repeat();
    logic [3:0] exp_v;
    in_pad = 1'b0;
    for (int k = 1; k <= 47; k++) begin
      step();
      exp_v = {k >= 7, k == 7, 1'b0, (k >= 15) && ((k - 7) % 8 == 0)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL auto_repeat k=%0d got %b expected %b", k, obs, exp_v);
      end
    end
    test_release("repeat_release", 15);
  endtask

  task automatic test_reset_held();
    logic [3:0] exp_v;
    in_pad = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_v = {k >= 7, k == 7, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL held_before_reset k=%0d got %b expected %b", k, obs, exp_v);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL held_in_reset got %b expected %b", obs, 4'b0000);
    end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_v = {k >= 7, k == 7, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL held_requalify k=%0d got %b expected %b", k, obs, exp_v);
      end
    end
    test_release("held_release", 10);
  endtask

  task automatic test_reset_drops_tick();
    logic [3:0] exp_v;
    in_pad = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL drop_pre k=%0d got %b expected %b", k, obs, 4'b0000);
      end
    end
    reset = 1'b1;
    step();
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL drop_tick got %b expected %b", obs, 4'b0000);
    end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_v = {k >= 7, k == 7, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL drop_requalify k=%0d got %b expected %b", k, obs, exp_v);
      end
    end
    test_release("drop_release", 10);
  endtask

  initial begin
    reset  = 1'b1;
    in_pad = 1'b1;
    test_reset();
    test_power_up();
    test_clean_press();
    test_bounce_reject();
    test_min_press();
    test_bounced_press();
    test_auto_repeat();
    test_reset_held();
    test_reset_drops_tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
